// File: rtl/reverb_stream_pkg.sv
// Shared types and constants for the reverb stream sink.
//  - state_e : sink FSM states (IDLE, PRIME, RUN)
//  - STREAM_W/SAMPLE_W : default packed stereo word width and per-channel width
//  - LEFT_*/RIGHT_* : channel field positions inside the default 32-bit word
//  - sample_w() : per-channel width for any stream width
package reverb_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int STREAM_W  = 32;
    localparam int SAMPLE_W  = STREAM_W / 2;
    localparam int LEFT_MSB  = STREAM_W - 1;
    localparam int LEFT_LSB  = SAMPLE_W;
    localparam int RIGHT_MSB = SAMPLE_W - 1;
    localparam int RIGHT_LSB = 0;

    function automatic int sample_w(input int data_w);
        return data_w / 2;
    endfunction

endpackage

// File: rtl/reverb_frame_buffer.sv
// DEPTH x DATA_W circular frame buffer built from flops.
//  clk, reset     : clock, synchronous active-high reset
//  push, wdata    : write request and frame; ignored when full unless a pop
//                   happens in the same cycle (pop is taken first)
//  pop            : release head frame; ignored when empty
//  flush          : empty the buffer (wins over push/pop)
//  head           : frame at the read pointer
//  fill_level     : frames held, 0..DEPTH
//  full, empty    : fill_level == DEPTH / == 0
module reverb_frame_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]               fill_q, fill_d;
    logic                         do_push, do_pop;

    assign full       = (fill_q == (PTR_W+1)'(DEPTH));
    assign empty      = (fill_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign fill_level = fill_q;

    always_comb begin
        do_pop   = pop & ~empty;
        // A same-cycle pop frees the slot the push needs.
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fill_d = fill_q + 1'b1;
                2'b01:   fill_d = fill_q - 1'b1;
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/reverb_st_stereo_sink.sv
// Avalon-ST stereo sink feeding the reverb core: buffers {L,R} frames from
// the m2s FIFO and releases one frame per sample_tick.
//  clk, reset            : clock, synchronous active-high reset
//  enable                : 1 = accept and play, 0 = flush and emit silence
//  asi_data/asi_valid    : stream word {left, right}, readyLatency = 1
//  asi_ready             : sink can take a word next cycle
//  sample_tick           : audio-rate strobe
//  left_out/right_out    : registered samples, held between ticks
//  sample_valid          : pulses the cycle after each tick
//  fill_level            : frames buffered
//  underrun_count        : saturating RUN-state underrun count
//  overrun               : sticky, word arrived while buffer full
//  status_clr            : clears underrun_count and overrun
module reverb_st_stereo_sink
    import reverb_stream_pkg::*;
#(
    parameter int DATA_W      = STREAM_W,
    parameter int DEPTH       = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [DATA_W-1:0]          asi_data,
    input  logic                       asi_valid,
    output logic                       asi_ready,
    input  logic                       sample_tick,
    output logic [DATA_W/2-1:0]        left_out,
    output logic [DATA_W/2-1:0]        right_out,
    output logic                       sample_valid,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [CNT_W-1:0]           underrun_count,
    output logic                       overrun,
    input  logic                       status_clr
);
    localparam int SW    = sample_w(DATA_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W+1:0] READY_LIM = (PTR_W+2)'(DEPTH - 1);
    localparam logic [PTR_W:0]   PRIME_LVL = (PTR_W+1)'(PRIME_LEVEL);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [SW-1:0]     left_q, left_d, right_q, right_d;
    logic              sval_q, sval_d;
    logic [CNT_W-1:0]  ucnt_q, ucnt_d;
    logic              ovr_q, ovr_d;

    logic              active, push, pop, underrun;
    logic [DATA_W-1:0] head;
    logic [PTR_W:0]    fill;
    logic              full, empty;
    logic [PTR_W+1:0]  credit;

    reverb_frame_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (~active),
        .wdata      (asi_data),
        .head       (head),
        .fill_level (fill),
        .full       (full),
        .empty      (empty)
    );

    assign active = enable & (state_q != ST_IDLE);
    // Count the word possibly in flight against free space; pops are not
    // credited, so legal upstream traffic can never overflow the buffer.
    assign credit    = {1'b0, fill} + {{(PTR_W+1){1'b0}}, ready_q};
    assign asi_ready = active & (credit <= READY_LIM);
    // Words landing while idle (or while enable just dropped) are discarded.
    assign push      = asi_valid & active;

    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        right_d  = right_q;
        sval_d   = 1'b0;
        pop      = 1'b0;
        underrun = 1'b0;
        ready_d  = asi_ready;

        if (sample_tick) begin
            sval_d  = 1'b1;
            left_d  = '0;
            right_d = '0;
            if (enable && state_q == ST_RUN) begin
                if (!empty) begin
                    pop     = 1'b1;
                    left_d  = head[DATA_W-1:SW];
                    right_d = head[SW-1:0];
                end else begin
                    underrun = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE:  state_d = ST_PRIME;
            ST_PRIME: if (fill >= PRIME_LVL) state_d = ST_RUN;
            ST_RUN:   if (underrun) state_d = ST_PRIME;
            default:  state_d = ST_IDLE;
        endcase
        if (!enable) state_d = ST_IDLE;

        // Clear wins over a same-cycle underrun or overrun event.
        if (status_clr) begin
            ucnt_d = '0;
            ovr_d  = 1'b0;
        end else begin
            ucnt_d = (underrun && ucnt_q != '1) ? ucnt_q + 1'b1 : ucnt_q;
            ovr_d  = ovr_q | (push & full & ~pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
            sval_q  <= 1'b0;
            ucnt_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            left_q  <= left_d;
            right_q <= right_d;
            sval_q  <= sval_d;
            ucnt_q  <= ucnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign left_out       = left_q;
    assign right_out      = right_q;
    assign sample_valid   = sval_q;
    assign fill_level     = fill;
    assign underrun_count = ucnt_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_reverb_st_stereo_sink.sv
module tb_reverb_st_stereo_sink;
    import reverb_stream_pkg::*;

    localparam int DEPTH = 4;
    localparam int PL    = 2;
    // Narrow counter so saturation is reachable in a short run.
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int VW    = 16 + 16 + 1 + 3 + CNT_W + 1 + 1;

    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2;

    logic              clk = 1'b0;
    logic              reset, enable, asi_valid, sample_tick, status_clr;
    logic [31:0]       asi_data;
    logic              asi_ready, sample_valid, overrun;
    logic [15:0]       left_out, right_out;
    logic [2:0]        fill_level;
    logic [CNT_W-1:0]  underrun_count;

    reverb_st_stereo_sink #(
        .DATA_W(32), .DEPTH(DEPTH), .PRIME_LEVEL(PL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .asi_data(asi_data), .asi_valid(asi_valid), .asi_ready(asi_ready),
        .sample_tick(sample_tick), .left_out(left_out), .right_out(right_out),
        .sample_valid(sample_valid), .fill_level(fill_level),
        .underrun_count(underrun_count), .overrun(overrun),
        .status_clr(status_clr)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Behavioural reference: a frame queue plus the observable status.
    logic [31:0] m_q[$];
    int          m_st;
    logic [15:0] m_l, m_r;
    logic        m_sv, m_ov, m_rdy_prev;
    int          m_cnt;

    wire [VW-1:0] dut_vec = {left_out, right_out, sample_valid, fill_level,
                             underrun_count, overrun, asi_ready};

    function automatic logic exp_ready();
        return enable && m_st != M_IDLE && (m_q.size() + int'(m_rdy_prev) <= DEPTH - 1);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_l, m_r, m_sv, 3'(m_q.size()), CNT_W'(m_cnt), m_ov, exp_ready()};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_st = M_IDLE; m_l = '0; m_r = '0; m_sv = 0; m_ov = 0; m_cnt = 0; m_rdy_prev = 0;
    endtask

    task automatic model_step();
        logic        r, live, popped, und, ovf;
        int          sz;
        logic [31:0] f;
        r      = exp_ready();
        sz     = m_q.size();
        live   = enable && m_st != M_IDLE;
        popped = 0; und = 0; ovf = 0;
        m_sv   = sample_tick;
        if (sample_tick) begin
            m_l = '0; m_r = '0;
            if (enable && m_st == M_RUN) begin
                if (sz > 0) begin
                    f = m_q.pop_front();
                    m_l = f[LEFT_MSB:LEFT_LSB];
                    m_r = f[RIGHT_MSB:RIGHT_LSB];
                    popped = 1;
                end else und = 1;
            end
        end
        if (asi_valid && live) begin
            if (sz == DEPTH && !popped) ovf = 1;
            else m_q.push_back(asi_data);
        end
        if (!live) m_q.delete();
        if (!enable) m_st = M_IDLE;
        else if (m_st == M_IDLE) m_st = M_PRIME;
        else if (m_st == M_PRIME && sz >= PL) m_st = M_RUN;
        else if (m_st == M_RUN && und) m_st = M_PRIME;
        if (status_clr) begin
            m_cnt = 0; m_ov = 0;
        end else begin
            if (und && m_cnt < MAXC) m_cnt++;
            if (ovf) m_ov = 1;
        end
        m_rdy_prev = r;
    endtask

    // Advance model and DUT by one clock; outputs are sampled 1 ns later.
    task automatic step();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        logic done;
        done = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            asi_valid = m_rdy_prev; asi_data = d; done = m_rdy_prev;
            step();
        end
        asi_valid = 0;
        nvec++;
        if (!done) begin nerr++; $display("FAIL push_timeout word %h not accepted in 8 cycles", d); end
    endtask

    task automatic hold_valid(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            asi_valid = m_rdy_prev; asi_data = $urandom;
            step();
        end
        asi_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; asi_valid = 1; asi_data = 32'hDEAD_BEEF;
        sample_tick = 1; status_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (left_out !== 16'h0) begin nerr++; $display("FAIL reset_left got %h exp 0", left_out); end
        nvec++; if (right_out !== 16'h0) begin nerr++; $display("FAIL reset_right got %h exp 0", right_out); end
        nvec++; if (sample_valid !== 1'b0) begin nerr++; $display("FAIL reset_sval got %b exp 0", sample_valid); end
        nvec++; if (fill_level !== 3'd0) begin nerr++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
        nvec++; if (underrun_count !== '0) begin nerr++; $display("FAIL reset_cnt got %0d exp 0", underrun_count); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        nvec++; if (asi_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready got %b exp 0", asi_ready); end
        enable = 0; asi_valid = 0; sample_tick = 0;
        @(negedge clk); reset = 0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        enable = 1;
        step(); step();
        push_word(32'h1234_ABCD);
        push_word(32'h0001_FFFF);
        step();
        sample_tick = 1; step();
        nvec++; if ({left_out, right_out, sample_valid} !== {16'h1234, 16'hABCD, 1'b1}) begin
            nerr++; $display("FAIL basic_frame0 got %h/%h v%b exp 1234/abcd v1", left_out, right_out, sample_valid); end
        step();
        nvec++; if ({left_out, right_out, sample_valid} !== {16'h0001, 16'hFFFF, 1'b1}) begin
            nerr++; $display("FAIL basic_frame1 got %h/%h v%b exp 0001/ffff v1", left_out, right_out, sample_valid); end
        sample_tick = 0; step();
        nvec++; if ({left_out, right_out, sample_valid} !== {16'h0001, 16'hFFFF, 1'b0}) begin
            nerr++; $display("FAIL basic_hold got %h/%h v%b exp 0001/ffff v0", left_out, right_out, sample_valid); end
        nvec++; if (dut_vec !== exp_vec()) begin nerr++; $display("FAIL basic_vec got %h exp %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_fill();
        hold_valid(10);
        nvec++; if (fill_level !== 3'd4) begin nerr++; $display("FAIL fill_level got %0d exp 4", fill_level); end
        nvec++; if (asi_ready !== 1'b0) begin nerr++; $display("FAIL fill_ready got %b exp 0", asi_ready); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL fill_ovr got %b exp 0", overrun); end
        sample_tick = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            nvec++; if (dut_vec !== exp_vec()) begin nerr++; $display("FAIL fill_drain%0d got %h exp %h", k, dut_vec, exp_vec()); end
        end
        sample_tick = 0;
    endtask

    task automatic test_underrun();
        logic [31:0] w1, w2;
        w1 = $urandom; w2 = $urandom;
        push_word($urandom);
        sample_tick = 1; step(); step(); sample_tick = 0;
        nvec++; if ({left_out, right_out, sample_valid} !== {32'h0, 1'b1}) begin
            nerr++; $display("FAIL under_out got %h/%h v%b exp 0/0 v1", left_out, right_out, sample_valid); end
        nvec++; if (underrun_count !== CNT_W'(1)) begin nerr++; $display("FAIL under_cnt got %0d exp 1", underrun_count); end
        sample_tick = 1; step(); sample_tick = 0;
        nvec++; if ({left_out, right_out, underrun_count} !== {32'h0, CNT_W'(1)}) begin
            nerr++; $display("FAIL under_prime_tick got %h/%h c%0d exp 0/0 c1", left_out, right_out, underrun_count); end
        push_word(w1); push_word(w2); step();
        sample_tick = 1; step(); sample_tick = 0;
        nvec++; if ({left_out, right_out} !== w1) begin nerr++; $display("FAIL under_rerun got %h%h exp %h", left_out, right_out, w1); end
        sample_tick = 1; step(); sample_tick = 0;
        nvec++; if ({left_out, right_out} !== w2) begin nerr++; $display("FAIL under_rerun2 got %h%h exp %h", left_out, right_out, w2); end
    endtask

    task automatic test_overrun();
        hold_valid(10);
        asi_valid = 1; asi_data = 32'hBAD0_BAD0; step(); asi_valid = 0;
        nvec++; if ({overrun, fill_level} !== {1'b1, 3'd4}) begin
            nerr++; $display("FAIL ovr_set got ovr%b fill%0d exp ovr1 fill4", overrun, fill_level); end
        status_clr = 1; step(); status_clr = 0;
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL ovr_clr got %b exp 0", overrun); end
        asi_valid = 1; asi_data = 32'h5555_AAAA; sample_tick = 1; step();
        asi_valid = 0; sample_tick = 0;
        nvec++; if ({overrun, fill_level} !== {1'b0, 3'd4}) begin
            nerr++; $display("FAIL ovr_tick got ovr%b fill%0d exp ovr0 fill4", overrun, fill_level); end
        nvec++; if (dut_vec !== exp_vec()) begin nerr++; $display("FAIL ovr_vec got %h exp %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_disable();
        sample_tick = 1; step(); step(); sample_tick = 0;
        step();
        enable = 0; asi_valid = m_rdy_prev; asi_data = 32'h7777_1111;
        step(); asi_valid = 0;
        step();
        nvec++; if ({fill_level, asi_ready, overrun} !== {3'd0, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL dis_flush got fill%0d rdy%b ovr%b exp 0 0 0", fill_level, asi_ready, overrun); end
        sample_tick = 1; step(); sample_tick = 0;
        nvec++; if ({left_out, right_out, sample_valid} !== {32'h0, 1'b1}) begin
            nerr++; $display("FAIL dis_tick got %h/%h v%b exp 0/0 v1", left_out, right_out, sample_valid); end
        nvec++; if (dut_vec !== exp_vec()) begin nerr++; $display("FAIL dis_vec got %h exp %h", dut_vec, exp_vec()); end
        enable = 1; step(); step();
    endtask

    task automatic test_saturate();
        for (int n = 0; n < MAXC + 2; n++) begin
            push_word($urandom); push_word($urandom); step();
            sample_tick = 1; step(); step(); step(); sample_tick = 0;
        end
        nvec++; if (underrun_count !== CNT_W'(MAXC)) begin
            nerr++; $display("FAIL sat_cnt got %0d exp %0d", underrun_count, MAXC); end
        push_word($urandom); push_word($urandom); step();
        sample_tick = 1; step(); step();
        status_clr = 1; step(); status_clr = 0; sample_tick = 0;
        nvec++; if (underrun_count !== '0) begin nerr++; $display("FAIL sat_clr got %0d exp 0", underrun_count); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            enable      = ($urandom_range(0, 49) != 0);
            sample_tick = ($urandom_range(0, 3) == 0);
            status_clr  = ($urandom_range(0, 39) == 0);
            asi_data    = $urandom;
            asi_valid   = ($urandom_range(0, 63) == 0) ? 1'b1 : (m_rdy_prev & 1'($urandom_range(0, 1)));
            step();
            nvec++; if (dut_vec !== exp_vec()) begin nerr++; $display("FAIL rand%0d got %h exp %h", k, dut_vec, exp_vec()); end
        end
        asi_valid = 0; sample_tick = 0; status_clr = 0; enable = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_underrun();
        test_overrun();
        test_disable();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
